// File: rtl/bcd_lut_fetch.sv
// bcd_lut_fetch: fetches a 2-byte BCD LUT word over the memory bus (ADDR/DATA/MW out, Q in) and copies it low byte first to two IO registers; host side START/INDEX in, BUSY/DONE/ERR/VALUE out; define LUT_BOUNDS_EN to reject INDEX > MAX_INDEX
module bcd_lut_fetch #(
  parameter logic [7:0] BASE_ADDR   = 8'd0,
  parameter logic [7:0] OUT_LO_ADDR = 8'd250,
  parameter logic [7:0] OUT_HI_ADDR = 8'd251,
  parameter logic [7:0] MAX_INDEX   = 8'd29
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  INDEX,
  input  logic [7:0]  Q,
  output logic [7:0]  ADDR,
  output logic [7:0]  DATA,
  output logic        MW,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] VALUE
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN} state_t;
  state_t state;
  logic bad;
`ifdef LUT_BOUNDS_EN
  assign bad = INDEX > MAX_INDEX;
`else
  assign bad = 1'b0 & (INDEX > MAX_INDEX);
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ADDR  <= 8'd0;
      DATA  <= 8'd0;
      MW    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      VALUE <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (START) begin
          ERR <= bad;
          if (bad) begin
            state <= FIN;
            DONE  <= 1'b1;
          end else begin
            state <= RD_LO;
            ADDR  <= BASE_ADDR + {INDEX[6:0], 1'b0};
            BUSY  <= 1'b1;
          end
        end
        RD_LO: begin
          state      <= RD_HI;
          VALUE[7:0] <= Q;
          ADDR       <= ADDR + 8'd1;
        end
        RD_HI: begin
          state       <= WR_LO;
          VALUE[15:8] <= Q;
          ADDR        <= OUT_LO_ADDR;
          DATA        <= VALUE[7:0];
          MW          <= 1'b1;
        end
        WR_LO: begin
          state <= WR_HI;
          ADDR  <= OUT_HI_ADDR;
          DATA  <= VALUE[15:8];
        end
        WR_HI: begin
          state <= FIN;
          ADDR  <= 8'd0;
          DATA  <= 8'd0;
          MW    <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          DONE  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_lut_fetch.sv
// tb_bcd_lut_fetch: table-driven, hand-sequenced and random checks of bcd_lut_fetch against a memory/IO model
module tb_bcd_lut_fetch;
  logic CLK = 1'b0, RESET = 1'b1, START = 1'b0;
  logic [7:0] INDEX = 8'd0, Q, ADDR, DATA, Q2, ADDR2, DATA2;
  logic MW, BUSY, DONE, ERR, MW2, BUSY2, DONE2, ERR2;
  logic [15:0] VALUE, VALUE2;
  logic [7:0] mem [0:255];
  logic [7:0] ioc = 8'h00, iod = 8'h00;
  int n_vec = 0, n_bad = 0;
  logic [7:0] lg_addr [1:12], lg2_addr [1:12];
  logic lg_mw [1:12], lg_done [1:12], lg_busy [1:12], lg_err [1:12];
  logic [15:0] lg_val [1:12];
  logic [15:0] prev = 16'h0000;
  typedef struct {logic [7:0] idx; logic [15:0] val;} vec_t;
  vec_t tbl [4];

  always #5 CLK = ~CLK;

  bcd_lut_fetch dut (.CLK(CLK), .RESET(RESET), .START(START), .INDEX(INDEX), .Q(Q),
    .ADDR(ADDR), .DATA(DATA), .MW(MW), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .VALUE(VALUE));
  bcd_lut_fetch #(.BASE_ADDR(8'd254)) dut2 (.CLK(CLK), .RESET(RESET), .START(START), .INDEX(INDEX), .Q(Q2),
    .ADDR(ADDR2), .DATA(DATA2), .MW(MW2), .BUSY(BUSY2), .DONE(DONE2), .ERR(ERR2), .VALUE(VALUE2));

  function automatic logic [7:0] rd(input int a);
    return (a % 256) >= 248 ? 8'h00 : mem[a % 256];
  endfunction
  function automatic logic [15:0] model_val(input int idx);
    int b;
    b = (2 * (idx % 128)) % 256;
    return {rd(b + 1), rd(b)};
  endfunction

  assign Q  = rd(int'(ADDR));
  assign Q2 = rd(int'(ADDR2));

  always @(posedge CLK)
    if (MW) begin
      if (ADDR == 8'd250) ioc <= DATA;
      else if (ADDR == 8'd251) iod <= DATA;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [7:0] idx, input int pulse_t, input int rst_t);
    START = 1'b1;
    INDEX = idx;
    @(posedge CLK);
    for (int t = 1; t <= 12; t++) begin
      @(negedge CLK);
      lg_addr[t] = ADDR; lg2_addr[t] = ADDR2; lg_mw[t] = MW; lg_done[t] = DONE;
      lg_busy[t] = BUSY; lg_err[t] = ERR; lg_val[t] = VALUE;
      START = (t == pulse_t);
      RESET = (t == rst_t);
    end
  endtask

  task automatic counts(output int first_done, output int n_done, output int n_mw, output int n_busy);
    first_done = 0; n_done = 0; n_mw = 0; n_busy = 0;
    for (int t = 1; t <= 12; t++) begin
      if (lg_done[t]) begin
        n_done++;
        if (first_done == 0) first_done = t;
      end
      if (lg_mw[t]) n_mw++;
      if (lg_busy[t]) n_busy++;
    end
  endtask

  task automatic check_fetch(input logic [7:0] idx, input logic [15:0] expv);
    int fd, nd, nm, nb, b;
    counts(fd, nd, nm, nb);
    b = (2 * (int'(idx) % 128)) % 256;
`ifdef LUT_BOUNDS_EN
    if (idx > 8'd29) begin
      chk("err_done_t", fd, 1);
      chk("err_mw", nm, 0);
      chk("err_flag", lg_err[1], 1);
      chk("err_value", VALUE, prev);
      return;
    end
`endif
    chk("done_t", fd, 5);
    chk("done_n", nd, 1);
    chk("mw_n", nm, 2);
    chk("busy_n", nb, 4);
    chk("rd_lo_addr", lg_addr[1], b);
    chk("rd_hi_addr", lg_addr[2], (b + 1) % 256);
    chk("wr_lo_addr", lg_addr[3], 250);
    chk("wr_hi_addr", lg_addr[4], 251);
    chk("value", VALUE, expv);
    chk("ioc", ioc, expv[7:0]);
    chk("iod", iod, expv[15:8]);
    chk("err_clr", ERR, 0);
    prev = expv;
  endtask

  initial begin
    int fd, nd, nm, nb, idx;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h08; mem[3] = 8'h00;
    mem[6] = 8'h26; mem[7] = 8'h00; mem[20] = 8'h98; mem[21] = 8'h00;
    mem[58] = 8'h59; mem[59] = 8'h02;
    tbl[0] = '{8'd3, 16'h0026};
    tbl[1] = '{8'd1, 16'h0008};
    tbl[2] = '{8'd0, 16'h0000};
    tbl[3] = '{8'd29, 16'h0259};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_outs", {ADDR, DATA, MW, BUSY, DONE, ERR}, 0);
    chk("rst_value", VALUE, 16'h0000);
    START = 1'b1; RESET = 1'b1; INDEX = 8'd3;
    @(negedge CLK);
    START = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    chk("start_rst_busy", {BUSY, MW, ADDR}, 0);
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].idx, 0, 0);
      check_fetch(tbl[i].idx, tbl[i].val);
      if (tbl[i].idx == 8'd0) begin
        chk("b254_rd_lo", lg2_addr[1], 254);
        chk("b254_rd_hi", lg2_addr[2], 255);
        chk("b254_value", VALUE2, 16'h0000);
      end
    end
    run(8'd10, 0, 3);
    counts(fd, nd, nm, nb);
    chk("rst_mid_mw_wr", lg_mw[3], 1);
    chk("rst_mid_outs", {lg_addr[4], lg_mw[4], lg_busy[4], lg_err[4]}, 0);
    chk("rst_mid_value", lg_val[4], 16'h0000);
    chk("rst_mid_done", nd, 0);
    chk("rst_mid_iod", iod, 8'h02);
    prev = 16'h0000;
    run(8'd1, 0, 0);
    check_fetch(8'd1, 16'h0008);
    run(8'd10, 1, 0);
    check_fetch(8'd10, 16'h0098);
`ifdef LUT_BOUNDS_EN
    run(8'd30, 0, 0);
    check_fetch(8'd30, 16'h0000);
    chk("err_held", ERR, 1);
    run(8'd0, 0, 0);
    check_fetch(8'd0, 16'h0000);
`endif
    for (int i = 0; i < 40; i++) begin
      idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 29)) : int'($urandom_range(0, 255));
`ifdef LUT_BOUNDS_EN
      run(8'(idx), 0, 0);
      check_fetch(8'(idx), idx > 29 ? prev : model_val(idx));
`else
      run(8'(idx), 0, 0);
      check_fetch(8'(idx), model_val(idx));
`endif
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_lut_fetch.md
# bcd_lut_fetch

Bus initiator for the data-memory/IO port: on request, reads one 2-byte BCD word from the heart-rate lookup table in data memory and copies it to two output IO registers, low byte first. It drives the same ADDR/DATA/MW bus the CPU uses and samples the memory's combinational read data Q. The host asserts START with an INDEX, then waits for DONE.

## Interface
- BASE_ADDR, 8'd0, byte address of LUT entry 0
- OUT_LO_ADDR, 8'd250, IO address receiving the low BCD byte
- OUT_HI_ADDR, 8'd251, IO address receiving the high BCD byte
- MAX_INDEX, 8'd29, last valid LUT index; used only when bounds checking is compiled in
- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request strobe; sampled only in IDLE
- INDEX  in  8  LUT entry number; captured with START
- Q  in  8  read data from memory; combinational in ADDR
- ADDR  out  8  bus address
- DATA  out  8  bus write data
- MW  out  1  bus write enable
- BUSY  out  1  high while a transfer is in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  index out of range; see Configuration
- VALUE  out  16  last fetched word, {hi, lo}

## Operation
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN.
- IDLE with START=1: capture base = BASE_ADDR + {INDEX[6:0],1'b0} (8-bit, wraps mod 256), then go to RD_LO. START in any other state is ignored and is not queued.
- RD_LO: ADDR=base, MW=0. Q is latched into VALUE[7:0] at the end of the cycle. Next state RD_HI.
- RD_HI: ADDR=base+1 (mod 256), MW=0. Q is latched into VALUE[15:8]. Next state WR_LO.
- WR_LO: ADDR=OUT_LO_ADDR, DATA=VALUE[7:0], MW=1. Next state WR_HI.
- WR_HI: ADDR=OUT_HI_ADDR, DATA=VALUE[15:8], MW=1. Next state FIN.
- FIN: DONE=1. Next state IDLE.
- IDLE/FIN bus levels: ADDR=0, DATA=0, MW=0.
- BUSY=1 in RD_LO, RD_HI, WR_LO, WR_HI.
- ADDR, DATA, MW, BUSY and DONE decode from registered state only. There is no combinational path from START, INDEX or Q to any output.
- Addresses that fall in 248..255 are not filtered. The block reads or writes IO space exactly as computed.

## Timing
- Reset values: state IDLE, ADDR=0, DATA=0, MW=0, BUSY=0, DONE=0, ERR=0, VALUE=16'h0000.
- START sampled high at edge k: RD_LO during cycle k+1, RD_HI k+2, WR_LO k+3, WR_HI k+4, DONE high during cycle k+5.
- Earliest next accepted START is at edge k+6, because IDLE is re-entered after FIN. Back-to-back throughput is one transfer per 6 cycles.
- MW is high for exactly 2 cycles per transfer and is never high in IDLE or FIN.
- RESET mid-transfer: the next edge forces all reset values. A pending write is abandoned, and MW is 0 from that edge onward. The memory's own RESET also reloads the LUT.
- START and RESET at the same edge: RESET wins and the request is dropped.

## Configuration
- LUT_BOUNDS_EN defined:
  - START with INDEX > MAX_INDEX goes IDLE→FIN with no bus cycles (MW stays 0), so DONE rises at cycle k+1.
  - ERR=1 from edge k until the next accepted START.
  - VALUE is unchanged.
  - A valid START clears ERR.
- LUT_BOUNDS_EN undefined: ERR is tied 0 and every INDEX is fetched, with address wrap-around.

## Test plan
- Reset, then INDEX=3 START:
  - Reads at addresses 6 and 7.
  - VALUE=16'h0026.
  - Writes 8'h26 to address 250 and 8'h00 to address 251.
  - DONE at k+5; IOC=8'h26, IOD=8'h00.
- INDEX=29: reads at 58 and 59; VALUE=16'h0259; IOC=8'h59, IOD=8'h02.
- START pulsed again at k+2 during INDEX=10: ignored. Exactly one DONE pulse, VALUE=16'h0098, and 2 MW cycles in total.
- RESET asserted during WR_LO:
  - MW=0 and all outputs at reset values from the next edge.
  - IOD is not written.
  - A new INDEX=1 fetch gives VALUE=16'h0008.
- LUT_BOUNDS_EN on, INDEX=30: no MW, DONE at k+1, ERR=1, VALUE unchanged. A following INDEX=0 START clears ERR and gives VALUE=16'h0000.
- BASE_ADDR=8'd254, INDEX=0 (bounds macro off): RD_LO address 254, RD_HI address 255 (IO space, reads Q=0), VALUE=16'h0000.
